// File: rtl/rotary_pkg.sv
// Shared types and the Gray-code step decoder for the rotary dial bank.
package rotary_pkg;

  typedef logic [1:0] quad_t;

  typedef enum logic [1:0] {STEP_NONE, STEP_CW, STEP_CCW, STEP_ERR} step_t;

  localparam quad_t QUAD_DETENT = 2'b00;

  // CW order is 00 -> 01 -> 11 -> 10 -> 00; a two-bit change is illegal.
  function automatic step_t decode_step(quad_t prev, quad_t cur);
    if (prev == cur) return STEP_NONE;
    if ((prev ^ cur) == 2'b11) return STEP_ERR;
    if (cur == {prev[0], ~prev[1]}) return STEP_CW;
    return STEP_CCW;
  endfunction

endpackage

// File: rtl/rotary_channel.sv
// One quadrature dial: 2-flop sync, stability filter, step decode and bounded
// position counter with clear/load.
module rotary_channel
  import rotary_pkg::*;
#(
  parameter int POS_W            = 8,
  parameter int POS_MAX          = 255,
  parameter int FILT_LEN         = 4,
  parameter int STEPS_PER_DETENT = 4,
  parameter int WRAP             = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  quad_t            rotary_in,
  input  logic             clear,
  input  logic             load,
  input  logic [POS_W-1:0] load_val,
  output logic [POS_W-1:0] rotary_pos,
  output logic             rot_cw,
  output logic             rot_ccw,
  output logic             rot_err
);

  localparam int               CNT_W    = $clog2(FILT_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FILT_LEN);
  localparam logic [POS_W-1:0] POS_TOP  = POS_W'(POS_MAX);

  quad_t            sync1, sync2, last, filt;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [1:0]       vld_pipe;
  logic             primed, adopt;
  step_t            step;
  logic [POS_W-1:0] pos_nx;

  always_comb begin
    cnt_nx = '0;
    // Counting starts only once the sync chain holds real pin samples.
    if (vld_pipe[1]) begin
      if (sync2 != last)        cnt_nx = CNT_W'(1);
      else if (cnt != CNT_FULL) cnt_nx = cnt + 1'b1;
      else                      cnt_nx = cnt;
    end
    adopt = primed && (cnt_nx == CNT_FULL) && (sync2 != filt);
    step  = adopt ? decode_step(filt, sync2) : STEP_NONE;
    if (STEPS_PER_DETENT == 1 && step != STEP_ERR && sync2 != QUAD_DETENT)
      step = STEP_NONE;

    pos_nx = rotary_pos;
    if (clear)
      pos_nx = '0;
    else if (load)
      pos_nx = (load_val > POS_TOP) ? POS_TOP : load_val;
    else if (step == STEP_CW) begin
      if (rotary_pos != POS_TOP) pos_nx = rotary_pos + 1'b1;
      else if (WRAP != 0)        pos_nx = '0;
    end else if (step == STEP_CCW) begin
      if (rotary_pos != '0) pos_nx = rotary_pos - 1'b1;
      else if (WRAP != 0)   pos_nx = POS_TOP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1      <= '0;
      sync2      <= '0;
      last       <= '0;
      filt       <= '0;
      cnt        <= '0;
      vld_pipe   <= '0;
      primed     <= 1'b0;
      rotary_pos <= '0;
      rot_cw     <= 1'b0;
      rot_ccw    <= 1'b0;
      rot_err    <= 1'b0;
    end else begin
      sync1    <= rotary_in;
      sync2    <= sync1;
      last     <= sync2;
      vld_pipe <= {vld_pipe[0], 1'b1};
      cnt      <= cnt_nx;
      // First stable value after reset is taken as the reference, silently.
      if (!primed && cnt_nx == CNT_FULL) begin
        filt   <= sync2;
        primed <= 1'b1;
      end else if (adopt) begin
        filt   <= sync2;
      end
      rotary_pos <= pos_nx;
      rot_cw     <= (step == STEP_CW);
      rot_ccw    <= (step == STEP_CCW);
      rot_err    <= (step == STEP_ERR);
    end
  end

endmodule

// File: rtl/rotary_bank.sv
// Bank of NUM_CH independent quadrature dial decoders with packed outputs.
module rotary_bank
  import rotary_pkg::*;
#(
  parameter int NUM_CH           = 2,
  parameter int POS_W            = 8,
  parameter int POS_MAX          = 255,
  parameter int FILT_LEN         = 4,
  parameter int STEPS_PER_DETENT = 4,
  parameter int WRAP             = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2*NUM_CH-1:0]     rotary_in,
  input  logic [NUM_CH-1:0]       clear,
  input  logic [NUM_CH-1:0]       load,
  input  logic [POS_W-1:0]        load_val,
  output logic [NUM_CH*POS_W-1:0] rotary_pos,
  output logic [NUM_CH-1:0]       rot_cw,
  output logic [NUM_CH-1:0]       rot_ccw,
  output logic [NUM_CH-1:0]       rot_err
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    rotary_channel #(
      .POS_W(POS_W), .POS_MAX(POS_MAX), .FILT_LEN(FILT_LEN),
      .STEPS_PER_DETENT(STEPS_PER_DETENT), .WRAP(WRAP)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .rotary_in (rotary_in[2*c +: 2]),
      .clear     (clear[c]),
      .load      (load[c]),
      .load_val  (load_val),
      .rotary_pos(rotary_pos[POS_W*c +: POS_W]),
      .rot_cw    (rot_cw[c]),
      .rot_ccw   (rot_ccw[c]),
      .rot_err   (rot_err[c])
    );
  end

endmodule
